// File: rtl/reg_file_pkg.sv
// Shared defaults and packed-port indexing helper for the multi-port register file.
package reg_file_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // LSB offset of port `port` inside a flat {port N-1, ..., port 0} bus
  function automatic int rf_slice(input int port, input int width);
    return port * width;
  endfunction
endpackage

// File: rtl/reg_file_wr_sel.sv
// Priority write selector: which enabled write port (lowest index wins) targets `target`.
module reg_file_wr_sel
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_WR = 3,
  parameter int IDX_W  = (NUM_WR > 1) ? $clog2(NUM_WR) : 1
) (
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0]        target,
  output logic                     hit,
  output logic [IDX_W-1:0]         idx,
  output logic [DATA_W-1:0]        data
);
  // Scan high to low so the lowest-index match is the last assignment
  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    data = '0;
    for (int p = NUM_WR - 1; p >= 0; p--) begin
      if (wr_en[p] && wr_addr[rf_slice(p, ADDR_W) +: ADDR_W] == target) begin
        hit  = 1'b1;
        idx  = IDX_W'(p);
        data = wr_data[rf_slice(p, DATA_W) +: DATA_W];
      end
    end
  end
endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with r0 hardwired to zero, optional read bypass,
// busy scoreboard for hazard tracking and a registered write-collision flag.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 3,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     sb_set_en,
  input  logic [ADDR_W-1:0]        sb_set_addr,
  output logic [2**ADDR_W-1:0]     busy_vec,
  output logic                     wr_collide
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int IDX_W = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

  logic [DEPTH-1:0][DATA_W-1:0] rf_q;
  logic [DEPTH-1:0][DATA_W-1:0] sel_data;
  logic [DEPTH-1:0]             sel_hit;
  logic [DEPTH-1:0]             collide;

  // Entry 0 is a constant so reads of r0 fall out of the normal indexing
  assign rf_q[0]     = '0;
  assign sel_data[0] = '0;
  assign sel_hit[0]  = 1'b0;
  assign collide[0]  = 1'b0;
  assign busy_vec[0] = 1'b0;

  for (genvar r = 1; r < DEPTH; r++) begin : g_reg
    logic              hit;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] q;
    logic              busy;
    logic              coll;

    reg_file_wr_sel #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_WR(NUM_WR), .IDX_W(IDX_W)
    ) u_sel (
      .wr_en  (wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .target (ADDR_W'(r)),
      .hit    (hit),
      .idx    (idx),
      .data   (data)
    );

    // A new issue marking the register pending outranks the retiring write
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q    <= '0;
        busy <= 1'b0;
      end else begin
        if (hit) q <= data;
        if (sb_set_en && sb_set_addr == ADDR_W'(r)) busy <= 1'b1;
        else if (hit)                               busy <= 1'b0;
      end
    end

    // Any enabled port other than the winner hitting this register is a collision
    always_comb begin
      coll = 1'b0;
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_en[p] && wr_addr[rf_slice(p, ADDR_W) +: ADDR_W] == ADDR_W'(r) &&
            IDX_W'(p) != idx)
          coll = 1'b1;
      end
    end

    assign rf_q[r]     = q;
    assign sel_data[r] = data;
    assign sel_hit[r]  = hit;
    assign collide[r]  = coll;
    assign busy_vec[r] = busy;
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    assign a = rd_addr[rf_slice(k, ADDR_W) +: ADDR_W];

    // Bypass is suppressed under reset so reads show the cleared array
    always_comb begin
      if (a == '0)                                   d = '0;
      else if (BYPASS != 0 && rst_n && sel_hit[a])   d = sel_data[a];
      else                                           d = rf_q[a];
    end

    assign rd_data[rf_slice(k, DATA_W) +: DATA_W] = d;
    assign rd_busy[k] = busy_vec[a];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_collide <= 1'b0;
    else        wr_collide <= |collide;
  end
endmodule
